// File: rtl/ofs_fim_pcie_ss_rxcrdt_nch.sv
// PCIe SS RX credit tracker: AXI-S pass-through per channel, with freed buffer slots returned to the HIP as batched credit messages.
// Optional per-channel flush timer enabled by defining OFS_FIM_PCIE_SS_RXCRDT_FLUSH_TIMER_EN.
`timescale 1ns/1ps
module ofs_fim_pcie_ss_rxcrdt_nch #(
    parameter int NUM_CH       = 2,
    parameter int TDATA_WIDTH  = 512,
    parameter int BUFFER_DEPTH = 512,
    parameter int CRDT_THRESH  = 8,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               in_tvalid,
    output logic [NUM_CH-1:0]               in_tready,
    input  logic [NUM_CH-1:0]               in_tlast,
    input  logic [NUM_CH*TDATA_WIDTH-1:0]   in_tdata,
    input  logic [NUM_CH*TDATA_WIDTH/8-1:0] in_tkeep,
    output logic [NUM_CH-1:0]               out_tvalid,
    input  logic [NUM_CH-1:0]               out_tready,
    output logic [NUM_CH-1:0]               out_tlast,
    output logic [NUM_CH*TDATA_WIDTH-1:0]   out_tdata,
    output logic [NUM_CH*TDATA_WIDTH/8-1:0] out_tkeep,
    output logic                            rxcrdt_tvalid,
    input  logic                            rxcrdt_tready,
    output logic [18:0]                     rxcrdt_tdata,
    output logic                            init_done,
    output logic [NUM_CH-1:0]               crdt_err
);
    localparam int PW = $clog2(BUFFER_DEPTH + 1);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 8 || BUFFER_DEPTH < 1 || BUFFER_DEPTH > 65535 ||
        CRDT_THRESH < 1 || CRDT_THRESH > BUFFER_DEPTH || FLUSH_CYCLES < 1) begin : g_bad_param
        $error("ofs_fim_pcie_ss_rxcrdt_nch: illegal parameter combination");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    logic [CW-1:0]     init_ch;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     grant_ch;
    logic              grant_vld;
    logic              load_go;
    logic [NUM_CH-1:0] freed;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] load;
    logic [PW-1:0]     pending [NUM_CH];

    assign init_done  = (state == ST_RUN);
    assign out_tvalid = in_tvalid & {NUM_CH{init_done}};
    assign in_tready  = out_tready & {NUM_CH{init_done}};
    assign out_tlast  = in_tlast;
    assign out_tdata  = in_tdata;
    assign out_tkeep  = in_tkeep;
    assign freed      = out_tvalid & out_tready;

`ifdef OFS_FIM_PCIE_SS_RXCRDT_FLUSH_TIMER_EN
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    logic [FW-1:0] flush_cnt [NUM_CH];

    // Idle timer restarts on any activity so only a quiet channel with stranded credits flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) flush_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pending[c] == '0 || freed[c] || load[c]) flush_cnt[c] <= '0;
                else if (flush_cnt[c] != '1)                 flush_cnt[c] <= flush_cnt[c] + FW'(1);
            end
        end
    end
`endif

    always_comb begin
        eligible = '0;
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef OFS_FIM_PCIE_SS_RXCRDT_FLUSH_TIMER_EN
            eligible[c] = (pending[c] >= PW'(CRDT_THRESH)) ||
                          ((flush_cnt[c] >= FW'(FLUSH_CYCLES)) && (pending[c] != '0));
`else
            eligible[c] = (pending[c] != '0);
`endif
            if (rxcrdt_tvalid && (rxcrdt_tdata[18:16] == 3'(c))) eligible[c] = 1'b0;
        end
    end

    // Round-robin: scan downward so the eligible channel nearest rr_ptr wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (eligible[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CW'(idx);
            end
        end
    end

    assign load_go = (state == ST_RUN) && grant_vld && (!rxcrdt_tvalid || rxcrdt_tready);

    always_comb begin
        load = '0;
        for (int c = 0; c < NUM_CH; c++) load[c] = load_go && (grant_ch == CW'(c));
    end

    // A load takes the whole count, so a beat freed in the same cycle leaves exactly one pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) pending[c] <= '0;
            crdt_err <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (load[c]) begin
                    pending[c] <= freed[c] ? PW'(1) : '0;
                end else if (freed[c]) begin
                    if (pending[c] == PW'(BUFFER_DEPTH)) crdt_err[c] <= 1'b1;
                    else                                 pending[c] <= pending[c] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_INIT;
            init_ch       <= '0;
            rr_ptr        <= '0;
            rxcrdt_tvalid <= 1'b0;
            rxcrdt_tdata  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (!rxcrdt_tvalid) begin
                        rxcrdt_tvalid <= 1'b1;
                        rxcrdt_tdata  <= {3'(init_ch), 16'(BUFFER_DEPTH)};
                    end else if (rxcrdt_tready) begin
                        if (init_ch == CW'(NUM_CH - 1)) begin
                            state         <= ST_RUN;
                            rxcrdt_tvalid <= 1'b0;
                        end else begin
                            init_ch      <= init_ch + CW'(1);
                            rxcrdt_tdata <= {3'(init_ch + CW'(1)), 16'(BUFFER_DEPTH)};
                        end
                    end
                end
                default: begin
                    if (load_go) begin
                        rxcrdt_tvalid <= 1'b1;
                        rxcrdt_tdata  <= {3'(grant_ch), 16'(pending[grant_ch])};
                        rr_ptr        <= (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + CW'(1);
                    end else if (rxcrdt_tready) begin
                        rxcrdt_tvalid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ofs_fim_pcie_ss_rxcrdt_nch.sv
// Directed bench for ofs_fim_pcie_ss_rxcrdt_nch (NUM_CH=2, BUFFER_DEPTH=512, CRDT_THRESH=8, FLUSH_CYCLES=64).
`timescale 1ns/1ps
module tb_ofs_fim_pcie_ss_rxcrdt_nch;
    localparam int NC = 2;
    localparam int TW = 32;
    localparam int KW = TW / 8;

`ifdef OFS_FIM_PCIE_SS_RXCRDT_FLUSH_TIMER_EN
    localparam logic [18:0] SIM0 = 19'h00008;
    localparam int          SIM0_LAT = 9;
    localparam logic [18:0] SIM1 = 19'h00001;
    localparam int          SIM1_LAT = 74;
    localparam logic [18:0] BP_HELD = 19'h10008;
    localparam int          BP_N = 2;
    localparam logic [18:0] OV_HELD = 19'h00008;
`else
    localparam logic [18:0] SIM0 = 19'h00001;
    localparam int          SIM0_LAT = 2;
    localparam logic [18:0] SIM1 = 19'h00002;
    localparam int          SIM1_LAT = 4;
    localparam logic [18:0] BP_HELD = 19'h10001;
    localparam int          BP_N = 3;
    localparam logic [18:0] OV_HELD = 19'h00001;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     in_tvalid = '0, in_tready, in_tlast = '0;
    logic [NC*TW-1:0]  in_tdata = '0, out_tdata;
    logic [NC*KW-1:0]  in_tkeep = '0, out_tkeep;
    logic [NC-1:0]     out_tvalid, out_tready = '0, out_tlast;
    logic              rxcrdt_tvalid, rxcrdt_tready = 1'b0;
    logic [18:0]       rxcrdt_tdata;
    logic              init_done;
    logic [NC-1:0]     crdt_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [18:0] mq[$];
    int          mc[$];

    ofs_fim_pcie_ss_rxcrdt_nch #(
        .NUM_CH(NC), .TDATA_WIDTH(TW), .BUFFER_DEPTH(512), .CRDT_THRESH(8), .FLUSH_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep),
        .rxcrdt_tvalid(rxcrdt_tvalid), .rxcrdt_tready(rxcrdt_tready), .rxcrdt_tdata(rxcrdt_tdata),
        .init_done(init_done), .crdt_err(crdt_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every credit handshake with the cycle it completes in.
    always @(negedge clk) begin
        #2;
        if (rxcrdt_tvalid === 1'b1 && rxcrdt_tready === 1'b1) begin
            mq.push_back(rxcrdt_tdata);
            mc.push_back(cyc);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_tvalid = '1; out_tready = '1; rxcrdt_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rxcrdt_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", rxcrdt_tvalid); end
        checks++; if (rxcrdt_tdata !== 19'h0) begin errors++; $display("FAIL rst_tdata got %h exp 0", rxcrdt_tdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b exp 0", init_done); end
        checks++; if (crdt_err !== 2'b00) begin errors++; $display("FAIL rst_crdt_err got %b exp 00", crdt_err); end
        checks++; if (in_tready !== 2'b00) begin errors++; $display("FAIL rst_in_tready got %b exp 00", in_tready); end
        checks++; if (out_tvalid !== 2'b00) begin errors++; $display("FAIL rst_out_tvalid got %b exp 00", out_tvalid); end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (rxcrdt_tvalid !== 1'b1) begin errors++; $display("FAIL init0_tvalid got %b exp 1", rxcrdt_tvalid); end
        checks++; if (rxcrdt_tdata !== 19'h00200) begin errors++; $display("FAIL init0_tdata got %h exp 00200", rxcrdt_tdata); end
        checks++; if (in_tready !== 2'b00) begin errors++; $display("FAIL init0_in_tready got %b exp 00", in_tready); end
        @(negedge clk); #1;
        checks++; if (rxcrdt_tdata !== 19'h10200) begin errors++; $display("FAIL init1_tdata got %h exp 10200", rxcrdt_tdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init1_init_done got %b exp 0", init_done); end
        checks++; if (in_tready !== 2'b00) begin errors++; $display("FAIL init1_in_tready got %b exp 00", in_tready); end
        @(negedge clk); #1;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL run_init_done got %b exp 1", init_done); end
        checks++; if (rxcrdt_tvalid !== 1'b0) begin errors++; $display("FAIL run_tvalid got %b exp 0", rxcrdt_tvalid); end
        checks++; if (in_tready !== 2'b11) begin errors++; $display("FAIL run_in_tready got %b exp 11", in_tready); end
        checks++; if (out_tvalid !== 2'b11) begin errors++; $display("FAIL run_out_tvalid got %b exp 11", out_tvalid); end
        in_tvalid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        in_tvalid = 2'b11; out_tready = 2'b00; in_tlast = 2'b10;
        in_tdata = 64'hDEADBEEF_12345678; in_tkeep = 8'hA5;
        #1;
        checks++; if (out_tvalid !== 2'b11) begin errors++; $display("FAIL pt_out_tvalid got %b exp 11", out_tvalid); end
        checks++; if (in_tready !== 2'b00) begin errors++; $display("FAIL pt_in_tready got %b exp 00", in_tready); end
        checks++; if (out_tdata !== 64'hDEADBEEF_12345678) begin errors++; $display("FAIL pt_tdata got %h exp deadbeef12345678", out_tdata); end
        checks++; if (out_tkeep !== 8'hA5) begin errors++; $display("FAIL pt_tkeep got %h exp a5", out_tkeep); end
        checks++; if (out_tlast !== 2'b10) begin errors++; $display("FAIL pt_tlast got %b exp 10", out_tlast); end
        @(negedge clk);
        in_tvalid = 2'b00; out_tready = 2'b10; in_tlast = 2'b01;
        in_tdata = 64'h0123_4567_89AB_CDEF; in_tkeep = 8'h3C;
        #1;
        checks++; if (in_tready !== 2'b10) begin errors++; $display("FAIL pt_in_tready2 got %b exp 10", in_tready); end
        checks++; if (out_tvalid !== 2'b00) begin errors++; $display("FAIL pt_out_tvalid2 got %b exp 00", out_tvalid); end
        checks++; if (out_tdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL pt_tdata2 got %h exp 0123456789abcdef", out_tdata); end
        checks++; if (out_tlast !== 2'b01 || out_tkeep !== 8'h3C) begin errors++; $display("FAIL pt_tlast_tkeep2 got %b/%h exp 01/3c", out_tlast, out_tkeep); end
        @(negedge clk);
        out_tready = '0; in_tlast = '0;
        repeat (4) @(negedge clk);
        checks++; if (rxcrdt_tvalid !== 1'b0) begin errors++; $display("FAIL pt_no_credit got %b exp 0", rxcrdt_tvalid); end
    endtask

    task automatic test_return();
        int k;
        mq.delete(); mc.delete();
        rxcrdt_tready = 1'b1; out_tready = '1;
`ifdef OFS_FIM_PCIE_SS_RXCRDT_FLUSH_TIMER_EN
        @(negedge clk); k = cyc; in_tvalid = 2'b10;
        repeat (7) @(negedge clk);
        @(negedge clk); in_tvalid = '0;
        repeat (20) @(negedge clk);
        checks++; if (mq.size() !== 1) begin errors++; $display("FAIL thr_count got %0d exp 1", mq.size()); end
        if (mq.size() >= 1) begin
            checks++; if (mq[0] !== 19'h10008) begin errors++; $display("FAIL thr_data got %h exp 10008", mq[0]); end
            checks++; if (mc[0] !== k + 9) begin errors++; $display("FAIL thr_latency got %0d exp %0d", mc[0] - k, 9); end
        end
        mq.delete(); mc.delete();
        @(negedge clk); k = cyc; in_tvalid = 2'b01;
        repeat (2) @(negedge clk);
        @(negedge clk); in_tvalid = '0;
        repeat (80) @(negedge clk);
        checks++; if (mq.size() !== 1) begin errors++; $display("FAIL flush_count got %0d exp 1", mq.size()); end
        if (mq.size() >= 1) begin
            checks++; if (mq[0] !== 19'h00003) begin errors++; $display("FAIL flush_data got %h exp 00003", mq[0]); end
            checks++; if (mc[0] < k + 66 || mc[0] > k + 68) begin errors++; $display("FAIL flush_latency got %0d exp 64..66 after last beat", mc[0] - k - 2); end
        end
`else
        @(negedge clk); k = cyc; in_tvalid = 2'b01;
        repeat (2) @(negedge clk);
        @(negedge clk); in_tvalid = '0;
        repeat (10) @(negedge clk);
        checks++; if (mq.size() !== 2) begin errors++; $display("FAIL beat_count got %0d exp 2", mq.size()); end
        if (mq.size() >= 2) begin
            checks++; if (mq[0] !== 19'h00001 || mc[0] !== k + 2) begin errors++; $display("FAIL beat_msg0 got %h@%0d exp 00001@2", mq[0], mc[0] - k); end
            checks++; if (mq[1] !== 19'h00002 || mc[1] !== k + 4) begin errors++; $display("FAIL beat_msg1 got %h@%0d exp 00002@4", mq[1], mc[1] - k); end
        end
`endif
    endtask

    task automatic test_simultaneous();
        int k;
        int sum;
        mq.delete(); mc.delete();
        rxcrdt_tready = 1'b1; out_tready = '1;
        @(negedge clk); k = cyc; in_tvalid = 2'b01;
        repeat (8) @(negedge clk);
        @(negedge clk); in_tvalid = '0;
        repeat (100) @(negedge clk);
        sum = 0;
        foreach (mq[i]) sum += (mq[i][18:16] == 3'd0) ? int'(mq[i][15:0]) : 10000;
        checks++; if (sum !== 9) begin errors++; $display("FAIL sim_total got %0d exp 9", sum); end
        checks++; if (mq.size() < 2) begin errors++; $display("FAIL sim_count got %0d exp >=2", mq.size()); end
        if (mq.size() >= 2) begin
            checks++; if (mq[0] !== SIM0 || mc[0] !== k + SIM0_LAT) begin errors++; $display("FAIL sim_msg0 got %h@%0d exp %h@%0d", mq[0], mc[0] - k, SIM0, SIM0_LAT); end
            checks++; if (mq[1] !== SIM1 || mc[1] !== k + SIM1_LAT) begin errors++; $display("FAIL sim_msg1 got %h@%0d exp %h@%0d", mq[1], mc[1] - k, SIM1, SIM1_LAT); end
        end
    endtask

    task automatic test_backpressure_rr();
        int k;
        mq.delete(); mc.delete();
        rxcrdt_tready = 1'b0; out_tready = '1;
        @(negedge clk); k = cyc;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            in_tvalid = {(i < 8), (i < 12)};
            #1;
            if (i >= 10) begin
                checks++; if (rxcrdt_tvalid !== 1'b1 || rxcrdt_tdata !== BP_HELD) begin errors++; $display("FAIL bp_hold_%0d got %b/%h exp 1/%h", i, rxcrdt_tvalid, rxcrdt_tdata, BP_HELD); end
            end
        end
        @(negedge clk);
        in_tvalid = '0; rxcrdt_tready = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (mq.size() !== BP_N) begin errors++; $display("FAIL bp_count got %0d exp %0d", mq.size(), BP_N); end
        if (mq.size() >= 2) begin
            checks++; if (mq[0] !== BP_HELD || mc[0] !== k + 14) begin errors++; $display("FAIL bp_msg0 got %h@%0d exp %h@14", mq[0], mc[0] - k, BP_HELD); end
            checks++; if (mq[1] !== 19'h0000C || mc[1] !== k + 15) begin errors++; $display("FAIL bp_msg1 got %h@%0d exp 0000c@15", mq[1], mc[1] - k); end
        end
`ifndef OFS_FIM_PCIE_SS_RXCRDT_FLUSH_TIMER_EN
        if (mq.size() >= 3) begin
            checks++; if (mq[2] !== 19'h10007 || mc[2] !== k + 16) begin errors++; $display("FAIL bp_msg2 got %h@%0d exp 10007@16", mq[2], mc[2] - k); end
        end
`endif
    endtask

    task automatic test_overflow();
        mq.delete(); mc.delete();
        rxcrdt_tready = 1'b0; out_tready = '1;
        for (int i = 0; i < 530; i++) begin
            @(negedge clk); in_tvalid = 2'b01;
            if (i == 400) begin
                #1;
                checks++; if (crdt_err !== 2'b00) begin errors++; $display("FAIL ovf_early_err got %b exp 00", crdt_err); end
            end
        end
        @(negedge clk); in_tvalid = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (crdt_err !== 2'b01) begin errors++; $display("FAIL ovf_err got %b exp 01", crdt_err); end
        checks++; if (rxcrdt_tvalid !== 1'b1 || rxcrdt_tdata !== OV_HELD) begin errors++; $display("FAIL ovf_held got %b/%h exp 1/%h", rxcrdt_tvalid, rxcrdt_tdata, OV_HELD); end
        rxcrdt_tready = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (mq.size() !== 2) begin errors++; $display("FAIL ovf_count got %0d exp 2", mq.size()); end
        if (mq.size() >= 2) begin
            checks++; if (mq[0] !== OV_HELD) begin errors++; $display("FAIL ovf_msg0 got %h exp %h", mq[0], OV_HELD); end
            checks++; if (mq[1] !== 19'h00200) begin errors++; $display("FAIL ovf_capped got %h exp 00200", mq[1]); end
        end
        checks++; if (crdt_err !== 2'b01) begin errors++; $display("FAIL ovf_sticky got %b exp 01", crdt_err); end
    endtask

    task automatic test_mid_reset();
        rxcrdt_tready = 1'b0; out_tready = '1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); in_tvalid = 2'b10;
        end
        #1;
        checks++; if (rxcrdt_tvalid !== 1'b1) begin errors++; $display("FAIL mid_inflight got %b exp 1", rxcrdt_tvalid); end
        checks++; if (crdt_err !== 2'b01) begin errors++; $display("FAIL mid_err_before got %b exp 01", crdt_err); end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_return();
        test_simultaneous();
        test_backpressure_rr();
        test_overflow();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofs_fim_pcie_ss_rxcrdt_nch.md
# ofs_fim_pcie_ss_rxcrdt_nch

Parametrised RX credit tracker for the PCIe SS RX path, sitting at the output of the per-channel RX buffers in the FIM clock domain. It passes NUM_CH AXI-S streams through unchanged and counts each beat that leaves a buffer as one freed slot. It returns freed slots to the HIP as batched credit messages on a handshaked credit channel. After reset it advertises the initial BUFFER_DEPTH credits per channel, and it supports a threshold plus an optional flush timer.

## Interface
Parameters:
- NUM_CH, 2: number of streams/channels; legal range 1..8.
- TDATA_WIDTH, 512: data width per channel; TKEEP width is TDATA_WIDTH/8.
- BUFFER_DEPTH, 512: slots per channel buffer; legal range 1..65535.
- CRDT_THRESH, 8: minimum pending credits before a channel requests a return; legal range 1..BUFFER_DEPTH.
- FLUSH_CYCLES, 64: idle cycles after which a sub-threshold pending count is flushed; must be ≥1.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- in_tvalid / in_tready / in_tlast, in/out/in, NUM_CH: per-channel upstream handshake.
- in_tdata / in_tkeep, in, NUM_CH*TDATA_WIDTH / NUM_CH*TDATA_WIDTH/8: upstream payload, channel c at slice c.
- out_tvalid / out_tready / out_tlast, out/in/out, NUM_CH: downstream handshake.
- out_tdata / out_tkeep, out, same widths as the inputs: downstream payload.
- rxcrdt_tvalid, out, 1: credit message valid.
- rxcrdt_tready, in, 1: credit message accepted.
- rxcrdt_tdata, out, 19: [18:16] channel index, [15:0] credit count (beats).
- init_done, out, 1: initial advertisement complete.
- crdt_err, out, NUM_CH: sticky per-channel overflow error.

## Operation
- **Data pass-through.** The data path is combinational for tdata, tkeep, tlast and tvalid. out_tvalid[c] = in_tvalid[c] & init_done. in_tready[c] = out_tready[c] & init_done.
- **Freed slots.** A beat is freed in any cycle where out_tvalid[c] & out_tready[c].
- **State machine, INIT.** Entered on reset. Issues one message per channel in order 0..NUM_CH-1, each {c, BUFFER_DEPTH}. It advances to the next channel only on rxcrdt handshake. After the handshake for the last channel it moves to RUN.
- **State machine, RUN.** init_done=1. There is no exit except reset.
- **Pending counters.** pending[c] is clog2(BUFFER_DEPTH+1) bits wide. Each cycle it receives +1 for a freed beat and −N when a message of count N for channel c is loaded. Both apply in the same cycle: next = pending − N + 1.
- **Overflow.** If an increment would exceed BUFFER_DEPTH, pending saturates at BUFFER_DEPTH and crdt_err[c] sets. crdt_err clears only on reset.
- **Eligibility.** Channel c is eligible when pending[c] ≥ CRDT_THRESH, or when its flush condition holds (see Configuration). A channel whose message is currently held in the output register is not eligible.
- **Arbitration.** Round-robin among eligible channels, starting at the channel after the last grant. The pointer resets to 0.
- **Message load.** A message loads when the output register is empty or being accepted this cycle, so back-to-back messages are allowed. The loaded count is the full registered pending[c], and pending is debited at load.
- **Output register hold.** rxcrdt_tdata and rxcrdt_tvalid stay stable while rxcrdt_tvalid & ~rxcrdt_tready.

## Timing
- **Reset values.** rxcrdt_tvalid=0, rxcrdt_tdata=0, init_done=0, crdt_err=0, out_tvalid=0, in_tready=0. All pending counters, flush timers and the round-robin pointer are 0.
- **First message.** The INIT message for channel 0 appears in the first cycle after rst deasserts.
- **Reset mid-operation.** Any in-flight message is dropped and all pending counts are discarded. INIT re-advertises BUFFER_DEPTH for every channel.
- **Credit latency.** A beat freed in cycle t is in pending at t+1. With CRDT_THRESH=1, the earliest rxcrdt_tvalid is t+2.
- **Throughput.** One credit message per cycle maximum, with no bubble between accepted messages.
- **Lowest-level reset behaviour.** in_tready is low in every cycle before init_done, so no beats are freed during INIT.

## Configuration
- Macro: OFS_FIM_PCIE_SS_RXCRDT_FLUSH_TIMER_EN.
- **Defined.** Each channel has a counter flush_cnt[c]:
  - It resets to 0 whenever pending[c]==0, a freed beat occurs, or the channel is loaded.
  - Otherwise it increments, saturating.
  - The channel is eligible when flush_cnt[c] ≥ FLUSH_CYCLES and pending[c] > 0.
- **Not defined.** There are no flush counters and CRDT_THRESH is ignored. Any channel with pending > 0 is eligible, which gives per-cycle credit return and guarantees no stranded credits.

## Test plan
- **Reset/INIT.** NUM_CH=2, BUFFER_DEPTH=512, rxcrdt_tready=1. Release rst, then expect messages 0x00200 and 0x10200 on consecutive cycles. init_done rises the following cycle, and in_tready stays 0 until then.
- **Threshold.** CRDT_THRESH=8, with the timer macro defined. Send 8 beats on ch1 back-to-back, then expect exactly one message {1, 8}, two cycles after the 8th beat.
- **Flush.** With the macro defined, FLUSH_CYCLES=64, send 3 beats on ch0 and go idle. Expect {0, 3} 64–66 cycles after the last beat. With the macro undefined, expect per-beat returns.
- **Backpressure and round-robin.** Hold rxcrdt_tready=0 with ch0 and ch1 both eligible. The held message must stay stable. Beats continuing on ch0 accumulate. After release, grants alternate and the counts sum to the beats sent.
- **Simultaneous.** Make a load of {0, N} coincide with a ch0 freed beat. The next message for ch0 must account for that beat, and the total returned must equal the beats sent.
- **Overflow and mid-run reset.** Force more than 512 freed beats on ch0 with rxcrdt_tready=0, then expect crdt_err[0]=1 and pending capped at 512. Assert rst mid-stream, then expect crdt_err=0 and INIT to repeat.
